// File: rtl/skid_buffer64_3x.sv
// Three-lane valid/ready pipeline stage with a two-entry skid buffer.
// in_ready depends only on occupancy, so upstream sees a registered-quality ready.
module skid_buffer64_3x #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] outA,
   output logic [WIDTH-1:0] outB,
   output logic [WIDTH-1:0] outC,
   output logic [1:0]       count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] main_a_p0, main_b_p0, main_c_p0;
   logic [WIDTH-1:0] skid_a_p1, skid_b_p1, skid_c_p1;

   logic in_acc, out_acc;
   logic load_main_in, load_main_skid, load_skid, clr;

   assign in_ready  = ((state_q == EMPTY) || (state_q == ONE)) && !reset;
   assign out_valid = (state_q == ONE) || (state_q == TWO);
   assign in_acc    = in_valid && in_ready;
   assign out_acc   = out_valid && out_ready;

   always_comb begin
      count = 2'd0;
      case (state_q)
         ONE:     count = 2'd1;
         TWO:     count = 2'd2;
         default: count = 2'd0;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clr            = 1'b0;
      if (flush) begin
         state_d = EMPTY;
         clr     = 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_acc) begin
                  load_main_in = 1'b1;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (in_acc && out_acc) begin
                  load_main_in = 1'b1;
               end else if (in_acc) begin
                  load_skid = 1'b1;
                  state_d   = TWO;
               end else if (out_acc) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_acc) begin
                  load_main_skid = 1'b1;
                  state_d        = ONE;
               end
            end
            // unused encoding falls back to EMPTY
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   // stage p0: main register set, drives the outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_a_p0 <= '0;
         main_b_p0 <= '0;
         main_c_p0 <= '0;
      end else if (clr) begin
         main_a_p0 <= '0;
         main_b_p0 <= '0;
         main_c_p0 <= '0;
      end else if (load_main_in) begin
         main_a_p0 <= a;
         main_b_p0 <= b;
         main_c_p0 <= c;
      end else if (load_main_skid) begin
         main_a_p0 <= skid_a_p1;
         main_b_p0 <= skid_b_p1;
         main_c_p0 <= skid_c_p1;
      end
   end

   // stage p1: skid register set, filled only when main is stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_a_p1 <= '0;
         skid_b_p1 <= '0;
         skid_c_p1 <= '0;
      end else if (clr) begin
         skid_a_p1 <= '0;
         skid_b_p1 <= '0;
         skid_c_p1 <= '0;
      end else if (load_skid) begin
         skid_a_p1 <= a;
         skid_b_p1 <= b;
         skid_c_p1 <= c;
      end
   end

   assign outA = main_a_p0;
   assign outB = main_b_p0;
   assign outC = main_c_p0;

endmodule

// File: doc/skid_buffer64_3x.md
Name: skid_buffer64_3x

Overview:
- Three-lane, 64-bit pipeline stage with valid/ready flow control on both sides and a 2-entry skid for backpressure.
- It is the consumer-facing end of a pipeline boundary: it accepts a, b and c from an upstream stage, holds them while the downstream stage stalls, and presents them on outA, outB and outC.
- Used between CPU pipeline stages where the downstream stage can stall and the upstream stage must see a registered-quality ready.

Parameters:
WIDTH, 64, bit width of each of the three lanes a/b/c

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
flush  input  1  synchronous, active-high; discards all held entries
in_valid  input  1  upstream presents a valid triple on a/b/c
in_ready  output  1  block can accept a triple this cycle
a  input  WIDTH  lane A data in
b  input  WIDTH  lane B data in
c  input  WIDTH  lane C data in
out_valid  output  1  outA/outB/outC hold a valid triple
out_ready  input  1  downstream consumes the presented triple this cycle
outA  output  WIDTH  lane A data out
outB  output  WIDTH  lane B data out
outC  output  WIDTH  lane C data out
count  output  2  number of held entries (0..2)

Behaviour:
- Storage: main register set (drives outA/B/C) plus skid register set; each set holds three WIDTH-bit lanes.
- Handshakes: input accept = in_valid & in_ready. Output accept = out_valid & out_ready. Both are evaluated at posedge clk.
- States: EMPTY (count=0), ONE (main full, count=1), TWO (main and skid full, count=2).
- out_valid = (state != EMPTY).
- in_ready = (state != TWO) & ~reset. It depends only on state and reset, never on out_ready; there is no combinational in->out path.
- Transitions (flush clear):
  - EMPTY: input accept -> main<=in, go to ONE. Otherwise stay.
  - ONE, both accepts -> main<=in, stay ONE (full throughput, one triple per cycle).
  - ONE, input accept only -> skid<=in, go to TWO.
  - ONE, output accept only -> go to EMPTY.
  - ONE, neither -> hold.
  - TWO (in_ready=0): output accept -> main<=skid, go to ONE. Otherwise hold; main and skid stay stable.
- Ordering: strict FIFO. Triples leave in acceptance order. Lanes always move together; no lane mixing between triples.
- Latency: a triple accepted at edge N is visible on outA/B/C with out_valid=1 after edge N when the block was EMPTY. Zero bubbles under continuous flow.
- Data stability: while out_valid=1 and out_ready=0, outA/B/C must not change.
- flush: takes priority over every transition. At the next edge, state goes to EMPTY and main and skid are cleared to 0. A triple offered in the same cycle is dropped, even though in_ready=1.
- reset (async): immediately state=EMPTY, main and skid = 0, out_valid=0, count=0, outA/B/C=0, in_ready=0 while reset is asserted. in_ready=1 on the first cycle after deassertion. Reset mid-transfer discards all held data.
- Outputs in EMPTY: outA/B/C keep their last main value. Consumers must qualify them with out_valid.
- Illegal or unused state encodings recover to EMPTY.

Test Plan:
1. Reset mid-operation: fill to TWO with A=5,6; assert reset between edges -> out_valid=0, count=0, outA=0 immediately; after deassert in_ready=1 and the first new triple (7,11,15) appears alone.
2. Streaming: out_ready=1, in_valid=1 for 4 cycles with a=1,2,3,4 (b=a+10, c=a+20) -> outA=1,2,3,4 on consecutive cycles starting one edge after the first accept; count stays 1; in_ready stays 1.
3. Backpressure: out_ready=0, offer a=5 then a=6 then a=7 -> 5 and 6 accepted, count=2, in_ready=0, 7 held upstream; outA=5 stable; raise out_ready -> outA sequence 5,6,7, no loss or duplication.
4. Simultaneous accept in ONE: hold 8, offer 9 with out_ready=1 -> next cycle outA=9, count=1, skid unused.
5. Flush with concurrent input: in TWO (10,11), flush=1 with in_valid=1 and a=12 -> next cycle count=0, out_valid=0, outA=0; 12 never emerges.
6. Lane integrity: triples (a,b,c)=(0xFFFF_FFFF_FFFF_FFFF,0,0x8000_0000_0000_0001) and (1,2,3) under random out_ready -> each output triple exactly matches an input triple, in order.
